// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - per-pin synchroniser and debounce filter for a GPIO bank
//
// Purpose: brings raw asynchronous pad inputs into the hclk domain through a
// 2-flop synchroniser. It then debounces each pin with a programmable
// stability count and emits a one-cycle change strobe per pin.
//
// Configuration macro: GPIO_IN_FILTER_DEBOUNCE_EN
//   defined   - per-pin debounce counters present, db_limit honoured
//   undefined - counters removed, gpi follows the synchroniser output
//
// Ports:
//   hclk      in   1       clock
//   hresetn   in   1       asynchronous active-low reset
//   en        in   1       filter enable; 0 freezes counters and gpi, clears chg
//   db_limit  in   cnt_w   extra stable cycles required before gpi follows
//   pin_in    in   gpio_w  raw asynchronous pad inputs
//   gpi       out  gpio_w  debounced, synchronised pin levels
//   chg       out  gpio_w  one-cycle pulse coincident with a gpi change
module gpio_in_filter #(
  parameter int gpio_w = 8,
  parameter int cnt_w  = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              en,
  input  logic [cnt_w-1:0]  db_limit,
  input  logic [gpio_w-1:0] pin_in,
  output logic [gpio_w-1:0] gpi,
  output logic [gpio_w-1:0] chg
);

  logic [gpio_w-1:0] s1;
  logic [gpio_w-1:0] s2;

  // The synchroniser runs every cycle, independent of en, so that s2 is
  // already settled when filtering resumes.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
    end
  end

`ifdef GPIO_IN_FILTER_DEBOUNCE_EN

  localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);

  logic [cnt_w-1:0] cnt [gpio_w];

  // The counter clears on any cycle where s2 matches gpi. It can therefore
  // only reach db_limit while the pin has differed for that many consecutive
  // enabled cycles, and it never exceeds db_limit, so it cannot wrap. The
  // db_limit compare is live: lowering the limit mid-count takes effect at once.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      gpi <= '0;
      chg <= '0;
      for (int i = 0; i < gpio_w; i++) begin
        cnt[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < gpio_w; i++) begin
        if (s2[i] == gpi[i]) begin
          cnt[i] <= '0;
          chg[i] <= 1'b0;
        end else if (cnt[i] >= db_limit) begin
          gpi[i] <= s2[i];
          cnt[i] <= '0;
          chg[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + cnt_one;
          chg[i] <= 1'b0;
        end
      end
    end else begin
      chg <= '0;
    end
  end

`else

  // Without counters db_limit has no function; fold it into a sink so it
  // does not read as a dangling input.
  logic unused_db_limit;
  assign unused_db_limit = ^db_limit;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      gpi <= '0;
      chg <= '0;
    end else if (en) begin
      gpi <= s2;
      chg <= s2 ^ gpi;
    end else begin
      chg <= '0;
    end
  end

`endif

endmodule
